alu_result_stage: RTL and testbench

//  Registered output stage directly downstream of the 4-bit ALU slice. Captures

---
 rtl/alu_result_stage_if.sv | 30 +++
 rtl/alu_result_stage.sv | 96 +++++++++
 tb/tb_alu_result_stage.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// ALU-to-result-stage handshake bundle: input capture side and output consumer side.
// The master modport drives ALU outputs and out_ready; the stage uses the slave modport.
interface alu_result_stage_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_result;
    logic             in_cout;
    logic             in_ovf;
    logic             in_set;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero;
    logic             out_neg;
    logic             out_carry;
    logic             out_ovf;

    modport master (
        output in_valid, in_op, in_result, in_cout, in_ovf, in_set, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_neg, out_carry, out_ovf
    );

    modport slave (
        input  in_valid, in_op, in_result, in_cout, in_ovf, in_set, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_neg, out_carry, out_ovf
    );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: forms result+flags, buffers in a DEPTH-entry FIFO, counts overflows.
// Push visible on out_* next cycle; in_ready drops when full, no bypass, head holds while stalled.
module alu_result_stage #(
    parameter int WIDTH     = 4,
    parameter int DEPTH     = 2,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_stage_if.slave    bus,
    input  logic                 ovf_clr,
    output logic [OVF_CNT_W-1:0] ovf_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             zero;
        logic             neg;
        logic             carry;
        logic             ovf;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        last_q;
    entry_t        new_entry;
    entry_t        shown;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    always_comb begin
        new_entry = '0;
        // SLT: the true less-than is the sign corrected for overflow
        if (bus.in_op == 3'b111) begin
            new_entry.result = {{(WIDTH-1){1'b0}}, bus.in_set ^ bus.in_ovf};
        end else begin
            new_entry.result = bus.in_result;
        end
        if (bus.in_op[1:0] == 2'b10) begin
            new_entry.carry = bus.in_cout;
            new_entry.ovf   = bus.in_ovf;
        end
        new_entry.zero = (new_entry.result == '0);
        new_entry.neg  = new_entry.result[WIDTH-1];
    end

    assign bus.in_ready  = (count != FULL_CNT);
    assign bus.out_valid = (count != '0);
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;

    // When empty, present the last popped entry rather than a stale slot
    assign shown          = bus.out_valid ? mem[rd_ptr] : last_q;
    assign bus.out_result = shown.result;
    assign bus.out_zero   = shown.zero;
    assign bus.out_neg    = shown.neg;
    assign bus.out_carry  = shown.carry;
    assign bus.out_ovf    = shown.ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            last_q    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ovf_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                last_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ovf_clr) begin
                ovf_count <= '0;
            end else if (push && new_entry.ovf && (ovf_count != '1)) begin
                ovf_count <= ovf_count + OVF_CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: vector table, hand sequences and random traffic vs a queue model.
module tb_alu_result_stage;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [3:0] result;
        logic       zero;
        logic       neg;
        logic       carry;
        logic       ovf;
    } exp_t;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] res;
        logic       z;
        logic       n;
        logic       c;
        logic       o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] ovf_count;
    logic [2:0] cur_op = 3'b000;
    logic [3:0] cur_a = 4'd0;
    logic [3:0] cur_b = 4'd0;

    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q[$];
    exp_t last_pop = '0;
    int   mcnt = 0;
    vec_t vecs[10];
    logic [2:0] ops[5];

    alu_result_stage_if #(.WIDTH(4)) bus ();

    alu_result_stage #(.WIDTH(4), .DEPTH(DEPTH), .OVF_CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ovf_clr   (ovf_clr),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-level ALU slice producing the raw signals the stage consumes
    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic ordy);
        logic [3:0] bb;
        logic [4:0] s;
        bb = op[2] ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {4'b0, op[2]};
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.out_ready = ordy;
        case (op[1:0])
            2'b00:   bus.in_result = a & bb;
            2'b01:   bus.in_result = a | bb;
            2'b10:   bus.in_result = s[3:0];
            default: bus.in_result = {3'b000, s[3]};
        endcase
        bus.in_cout = s[4];
        bus.in_ovf  = (a[3] == bb[3]) && (s[3] != a[3]);
        bus.in_set  = s[3];
        cur_op = op;
        cur_a  = a;
        cur_b  = b;
    endtask

    // Expected entry from instruction semantics with integer arithmetic
    function automatic exp_t model_entry(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        exp_t e;
        int sa;
        int sb;
        int r;
        e  = '0;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'b000: e.result = a & b;
            3'b001: e.result = a | b;
            3'b010: begin
                r = sa + sb;
                e.result = a + b;
                e.carry  = (int'(a) + int'(b)) > 15;
                e.ovf    = (r > 7) || (r < -8);
            end
            3'b110: begin
                r = sa - sb;
                e.result = a - b;
                e.carry  = (a >= b);
                e.ovf    = (r > 7) || (r < -8);
            end
            default: e.result = (sa < sb) ? 4'd1 : 4'd0;
        endcase
        e.zero = (e.result == 4'd0);
        e.neg  = e.result[3];
        return e;
    endfunction

    function automatic void model_reset();
        q.delete();
        last_pop = '0;
        mcnt = 0;
    endfunction

    task automatic tick();
        bit   push;
        bit   pop;
        exp_t e;
        exp_t shown;
        push = bus.in_valid && (q.size() < DEPTH);
        pop  = (q.size() != 0) && bus.out_ready;
        e    = model_entry(cur_op, cur_a, cur_b);
        @(posedge clk);
        #1;
        if (pop) last_pop = q.pop_front();
        if (push) q.push_back(e);
        if (ovf_clr) mcnt = 0;
        else if (push && e.ovf && mcnt < 255) mcnt++;
        shown = (q.size() != 0) ? q[0] : last_pop;
        chk("out_valid", bus.out_valid, q.size() != 0);
        chk("in_ready", bus.in_ready, q.size() < DEPTH);
        chk("out_result", bus.out_result, shown.result);
        chk("out_zero", bus.out_zero, shown.zero);
        chk("out_neg", bus.out_neg, shown.neg);
        chk("out_carry", bus.out_carry, shown.carry);
        chk("out_ovf", bus.out_ovf, shown.ovf);
        chk("ovf_count", ovf_count, mcnt);
    endtask

    initial begin
        logic [3:0] exp_sum;
        //            op      a      b      res   z     n     c     o
        vecs[0] = '{3'b010, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{3'b110, 4'h3, 4'h3, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{3'b000, 4'hC, 4'hA, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{3'b001, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{3'b111, 4'h2, 4'h5, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{3'b111, 4'h7, 4'h8, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{3'b110, 4'h8, 4'h1, 4'h7, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{3'b010, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{3'b000, 4'h8, 4'h8, 4'h8, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{3'b001, 4'h5, 4'h2, 4'h7, 1'b0, 1'b0, 1'b0, 1'b0};
        ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

        drive(1'b0, 3'b000, 4'd0, 4'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", bus.out_valid, 1'b0);
        chk("reset in_ready", bus.in_ready, 1'b1);
        chk("reset out_result", bus.out_result, 4'd0);
        chk("reset ovf_count", ovf_count, 8'd0);
        rst_n = 1'b1;
        model_reset();

        // Vector table, one op per cycle with the consumer always ready
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1);
            tick();
            chk("vec out_valid", bus.out_valid, 1'b1);
            chk("vec result", bus.out_result, vecs[i].res);
            chk("vec zero", bus.out_zero, vecs[i].z);
            chk("vec neg", bus.out_neg, vecs[i].n);
            chk("vec carry", bus.out_carry, vecs[i].c);
            chk("vec ovf", bus.out_ovf, vecs[i].o);
            if (i == 0) chk("vec first ovf_count", ovf_count, 8'd1);
        end
        chk("table ovf_count", ovf_count, 8'd2);
        drive(1'b0, 3'b000, 4'd0, 4'd0, 1'b1);
        tick();

        // Backpressure: three back-to-back pushes into a stalled two-entry FIFO
        drive(1'b1, 3'b010, 4'd1, 4'd1, 1'b0);
        tick();
        drive(1'b1, 3'b010, 4'd2, 4'd2, 1'b0);
        tick();
        chk("bp full in_ready", bus.in_ready, 1'b0);
        drive(1'b1, 3'b010, 4'd3, 4'd3, 1'b0);
        tick();
        chk("bp stall head", bus.out_result, 4'd2);
        drive(1'b0, 3'b000, 4'd0, 4'd0, 1'b0);
        tick();
        chk("bp stable head", bus.out_result, 4'd2);
        drive(1'b0, 3'b000, 4'd0, 4'd0, 1'b1);
        tick();
        chk("bp second", bus.out_result, 4'd4);
        tick();
        chk("bp empty", bus.out_valid, 1'b0);
        chk("bp hold last", bus.out_result, 4'd4);

        // Push+pop when full pops only
        drive(1'b1, 3'b001, 4'd1, 4'd0, 1'b0);
        tick();
        tick();
        drive(1'b1, 3'b001, 4'd9, 4'd0, 1'b1);
        tick();
        chk("full push+pop in_ready", bus.in_ready, 1'b1);
        drive(1'b0, 3'b000, 4'd0, 4'd0, 1'b1);
        tick();
        tick();

        // Streaming: one result per cycle across pointer wrap
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 3'b010, 4'(i), 4'd3, 1'b1);
            chk("stream in_ready", bus.in_ready, 1'b1);
            tick();
            exp_sum = 4'(i + 3);
            chk("stream result", bus.out_result, exp_sum);
        end
        drive(1'b0, 3'b000, 4'd0, 4'd0, 1'b1);
        tick();

        // Overflow counter saturation and clear priority
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 3'b010, 4'd7, 4'd1, 1'b1);
            tick();
        end
        chk("sat ovf_count", ovf_count, 8'd255);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("clr wins ovf_count", ovf_count, 8'd0);

        // Asynchronous reset while full and mid-handshake
        drive(1'b1, 3'b010, 4'd7, 4'd1, 1'b0);
        tick();
        tick();
        chk("pre-reset full", bus.in_ready, 1'b0);
        drive(1'b1, 3'b010, 4'd7, 4'd1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid", bus.out_valid, 1'b0);
        chk("async rst in_ready", bus.in_ready, 1'b1);
        chk("async rst ovf_count", ovf_count, 8'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        drive(1'b0, 3'b000, 4'd0, 4'd0, 1'b1);
        tick();
        chk("post-reset result", bus.out_result, 4'd0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 3) != 0, ops[$urandom_range(0, 4)], 4'($urandom),
                  4'($urandom), $urandom_range(0, 2) != 0);
            ovf_clr = ($urandom_range(0, 29) == 0);
            tick();
        end
        ovf_clr = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
